vram_scanout: RTL and testbench

- Raster reader for the 8-bit port of the video RAM. The CPU writes the bitmap through the 16-bit port.
- Generates VGA-style horizontal/vertical timing and fetches one bitmap byte per 8×SCALE pixels.
- Serialises each byte MSB-first into a 1-bit monochrome pixel stream, with a scaled window placed inside the visible area.
- Sits between the video RAM byte port and the board video output pins.

---
 rtl/vram_video_pkg.sv | 44 ++++
 rtl/video_timing_gen.sv | 87 ++++++++
 rtl/vram_scanout.sv | 194 +++++++++++++++++++
 tb/tb_vram_scanout.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/vram_video_pkg.sv
// Shared timing defaults, widths and frame-size helpers for the VRAM scan-out path.
package vram_video_pkg;

    localparam int ADDR_W = 11;
    localparam int CNT_W  = 12;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam bit HS_POL_DEF    = 1'b0;
    localparam bit VS_POL_DEF    = 1'b0;
    localparam int BPL_DEF       = 32;
    localparam int LINES_DEF     = 64;
    localparam int SCALE_DEF     = 2;
    localparam int H_START_DEF   = 64;
    localparam int V_START_DEF   = 176;

    // Per-pixel attributes that travel down the output pipeline alongside the bitmap data.
    typedef struct packed {
        logic de;
        logic hsync;
        logic vsync;
        logic frame_start;
        logic win;
        logic en;
        logic inv;
    } pix_tag_t;

    function automatic int h_total(input int visible, input int front,
                                   input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    function automatic int v_total(input int visible, input int front,
                                   input int sync, input int back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster counters plus combinational decode of syncs, active area, window and frame start.
// All outputs describe the position currently held in the counters.
module video_timing_gen
    import vram_video_pkg::*;
#(
    parameter int H_VISIBLE   = H_VISIBLE_DEF,
    parameter int H_FRONT     = H_FRONT_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BACK      = H_BACK_DEF,
    parameter int V_VISIBLE   = V_VISIBLE_DEF,
    parameter int V_FRONT     = V_FRONT_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BACK      = V_BACK_DEF,
    parameter bit HS_POL      = HS_POL_DEF,
    parameter bit VS_POL      = VS_POL_DEF,
    parameter int H_WIN_START = H_START_DEF,
    parameter int H_WIN_END   = H_START_DEF + BPL_DEF * 8 * SCALE_DEF,
    parameter int V_WIN_START = V_START_DEF,
    parameter int V_WIN_END   = V_START_DEF + LINES_DEF * SCALE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] h_cnt_o,
    output logic [CNT_W-1:0] v_cnt_o,
    output logic             de_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             frame_start_o,
    output logic             win_row_o,
    output logic             in_win_o
);

    localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_C   = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_C   = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_BEGIN  = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEGIN  = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [CNT_W-1:0] HW_BEGIN  = CNT_W'(H_WIN_START);
    localparam logic [CNT_W-1:0] HW_END    = CNT_W'(H_WIN_END);
    localparam logic [CNT_W-1:0] VW_BEGIN  = CNT_W'(V_WIN_START);
    localparam logic [CNT_W-1:0] VW_END    = CNT_W'(V_WIN_END);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             hs_active;
    logic             vs_active;
    logic             win_col;

    always_comb begin
        h_d = h_q + CNT_W'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign hs_active = (h_q >= HS_BEGIN) && (h_q < HS_END);
    assign vs_active = (v_q >= VS_BEGIN) && (v_q < VS_END);
    assign win_col   = (h_q >= HW_BEGIN) && (h_q < HW_END);

    assign h_cnt_o       = h_q;
    assign v_cnt_o       = v_q;
    assign de_o          = (h_q < H_VIS_C) && (v_q < V_VIS_C);
    assign hsync_o       = hs_active ? HS_POL : ~HS_POL;
    assign vsync_o       = vs_active ? VS_POL : ~VS_POL;
    assign frame_start_o = (h_q == '0) && (v_q == '0);
    assign win_row_o     = (v_q >= VW_BEGIN) && (v_q < VW_END);
    assign in_win_o      = win_row_o && win_col;

endmodule

// File: rtl/vram_scanout.sv
// Reads the bitmap through the VRAM byte port and serialises it MSB-first into a
// 1-bit pixel stream; every output lags the raster counters by exactly three clocks.
module vram_scanout
    import vram_video_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter bit HS_POL    = HS_POL_DEF,
    parameter bit VS_POL    = VS_POL_DEF,
    parameter int BPL       = BPL_DEF,
    parameter int LINES     = LINES_DEF,
    parameter int SCALE     = SCALE_DEF,
    parameter int H_START   = H_START_DEF,
    parameter int V_START   = V_START_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              invert,
    output logic [ADDR_W-1:0] addr_a,
    input  logic [7:0]        q_a,
    output logic              video,
    output logic              de,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start
);

    localparam int WIN_W   = BPL * 8 * SCALE;
    localparam int WIN_H   = LINES * SCALE;
    localparam int BYTE_W  = 8 * SCALE;
    localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_START);
    localparam logic [CNT_W-1:0] WIN_W_C   = CNT_W'(WIN_W);
    localparam logic [CNT_W-1:0] BYTE_W_C  = CNT_W'(BYTE_W);
    localparam logic [CNT_W-1:0] SCALE_C   = CNT_W'(SCALE);
    localparam logic [CNT_W-1:0] BPL_C     = CNT_W'(BPL);

    localparam pix_tag_t TAG_RST = '{de: 1'b0, hsync: ~HS_POL, vsync: ~VS_POL,
                                     frame_start: 1'b0, win: 1'b0, en: 1'b0, inv: 1'b0};

    generate
        if (H_START < 4) begin : g_chk_hstart
            $error("vram_scanout: H_START must be at least 4");
        end
        if (SCALE < 1 || SCALE > 4) begin : g_chk_scale
            $error("vram_scanout: SCALE must be in 1..4");
        end
        if (H_START + WIN_W > H_VISIBLE || V_START + WIN_H > V_VISIBLE) begin : g_chk_fit
            $error("vram_scanout: bitmap window does not fit inside the visible area");
        end
        if (BPL * LINES > (1 << ADDR_W)) begin : g_chk_size
            $error("vram_scanout: bitmap larger than the byte address space");
        end
        if (H_TOTAL >= (1 << CNT_W) || V_TOTAL >= (1 << CNT_W)) begin : g_chk_cnt
            $error("vram_scanout: raster totals exceed counter width");
        end
    endgenerate

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             tg_de;
    logic             tg_hsync;
    logic             tg_vsync;
    logic             tg_frame_start;
    logic             win_row;
    logic             in_win;

    video_timing_gen #(
        .H_VISIBLE   (H_VISIBLE),
        .H_FRONT     (H_FRONT),
        .H_SYNC      (H_SYNC),
        .H_BACK      (H_BACK),
        .V_VISIBLE   (V_VISIBLE),
        .V_FRONT     (V_FRONT),
        .V_SYNC      (V_SYNC),
        .V_BACK      (V_BACK),
        .HS_POL      (HS_POL),
        .VS_POL      (VS_POL),
        .H_WIN_START (H_START),
        .H_WIN_END   (H_START + WIN_W),
        .V_WIN_START (V_START),
        .V_WIN_END   (V_START + WIN_H)
    ) u_timing (
        .clk           (clk),
        .rst           (rst),
        .h_cnt_o       (h_cnt),
        .v_cnt_o       (v_cnt),
        .de_o          (tg_de),
        .hsync_o       (tg_hsync),
        .vsync_o       (tg_vsync),
        .frame_start_o (tg_frame_start),
        .win_row_o     (win_row),
        .in_win_o      (in_win)
    );

    logic [CNT_W-1:0]  x_cur;
    logic [CNT_W-1:0]  x_nxt;
    logic [CNT_W-1:0]  y_off;
    logic              fetch;
    logic              ld0;
    logic              sh0;
    logic [ADDR_W-1:0] addr_q, addr_d;
    pix_tag_t          s1_d, s1_q, s2_q;
    logic              ld1_q, sh1_q;
    logic [7:0]        shift_q, shift_d;
    logic              video_d;
    logic              video_q, de_q, hsync_q, vsync_q, fs_q;

    // Offsets wrap to large values left of the window, so a single upper-bound test suffices.
    assign x_cur = h_cnt - H_START_C;
    assign x_nxt = h_cnt + CNT_W'(1) - H_START_C;
    assign y_off = v_cnt - V_START_C;

    // Address the byte one pixel ahead: RAM latency puts it on q_a as that pixel enters stage 1.
    assign fetch = win_row && (x_nxt < WIN_W_C) && ((x_nxt % BYTE_W_C) == '0);
    assign ld0   = in_win && ((x_cur % BYTE_W_C) == '0);
    assign sh0   = in_win && ((x_cur % SCALE_C) == '0);

    always_comb begin
        addr_d = addr_q;
        if (fetch) begin
            addr_d = ADDR_W'((y_off / SCALE_C) * BPL_C + x_nxt / BYTE_W_C);
        end
    end

    always_comb begin
        s1_d             = TAG_RST;
        s1_d.de          = tg_de;
        s1_d.hsync       = tg_hsync;
        s1_d.vsync       = tg_vsync;
        s1_d.frame_start = tg_frame_start;
        s1_d.win         = in_win;
        s1_d.en          = enable;
        s1_d.inv         = invert;
    end

    // A new byte wins over the per-bit shift on its first pixel.
    always_comb begin
        shift_d = shift_q;
        if (ld1_q) begin
            shift_d = q_a;
        end else if (sh1_q) begin
            shift_d = {shift_q[6:0], 1'b0};
        end
    end

    assign video_d = s2_q.de & s2_q.win & s2_q.en & (shift_q[7] ^ s2_q.inv);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            s1_q    <= TAG_RST;
            ld1_q   <= 1'b0;
            sh1_q   <= 1'b0;
            s2_q    <= TAG_RST;
            shift_q <= '0;
            video_q <= 1'b0;
            de_q    <= 1'b0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            fs_q    <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            s1_q    <= s1_d;
            ld1_q   <= ld0;
            sh1_q   <= sh0;
            s2_q    <= s1_q;
            shift_q <= shift_d;
            video_q <= video_d;
            de_q    <= s2_q.de;
            hsync_q <= s2_q.hsync;
            vsync_q <= s2_q.vsync;
            fs_q    <= s2_q.frame_start;
        end
    end

    assign addr_a      = addr_q;
    assign video       = video_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vram_scanout.sv
// Scan-out bench on a shrunken raster: a behavioural raster/pixel model predicts every output cycle.
`timescale 1ns/1ps
module tb_vram_scanout;

    localparam int HV = 64, HF = 4, HS = 8, HB = 4;
    localparam int VV = 24, VF = 2, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int BPL = 3, LINES = 8, SC = 2;
    localparam int HSTART = 6, VSTART = 3;
    localparam int WW = BPL * 8 * SC;
    localparam int WH = LINES * SC;
    localparam int LAST = BPL * LINES - 1;
    localparam logic [4:0] RST_VEC = 5'b00110;
    localparam int MAXC = 8192;

    logic        clk, rst, enable, invert;
    logic [10:0] addr_a;
    logic [7:0]  q_a;
    logic        video, de, hsync, vsync, frame_start;
    logic [4:0]  obs;

    logic [7:0] mem [0:2047];
    bit         en_hist  [0:MAXC-1];
    bit         inv_hist [0:MAXC-1];
    int         k;
    int         n_checks, n_pass;

    vram_scanout #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HS_POL(1'b0), .VS_POL(1'b0),
        .BPL(BPL), .LINES(LINES), .SCALE(SC), .H_START(HSTART), .V_START(VSTART)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .invert(invert),
        .addr_a(addr_a), .q_a(q_a),
        .video(video), .de(de), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM port: data for the sampled address appears one clock later.
    always @(posedge clk) q_a <= mem[addr_a];

    assign obs = {video, de, hsync, vsync, frame_start};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    endtask

    // Expected {video,de,hsync,vsync,frame_start} in cycle kk after reset release.
    function automatic logic [4:0] exp_vec(input int kk);
        int p, h, v, x, y;
        logic [7:0] b;
        logic e_de, e_hs, e_vs, e_fs, win, px, vid;
        if (kk < 3) return RST_VEC;
        p = kk - 3;
        h = p % HT;
        v = (p / HT) % VT;
        e_de = (h < HV) && (v < VV);
        e_hs = !((h >= HV + HF) && (h < HV + HF + HS));
        e_vs = !((v >= VV + VF) && (v < VV + VF + VS));
        e_fs = (h == 0) && (v == 0);
        win  = (h >= HSTART) && (h < HSTART + WW) && (v >= VSTART) && (v < VSTART + WH);
        px = 1'b0;
        if (win) begin
            x = h - HSTART;
            y = v - VSTART;
            b = mem[(y / SC) * BPL + x / (8 * SC)];
            px = b[7 - ((x / SC) % 8)];
        end
        vid = e_de & win & en_hist[p] & (px ^ inv_hist[p]);
        return {vid, e_de, e_hs, e_vs, e_fs};
    endfunction

    // Releases reset (caller is just past a rising edge) and checks n cycles.
    task automatic run_phase(input int n, input bit rand_inputs);
        rst = 1'b0;
        k = 0;
        for (int i = 0; i < n; i++) begin
            int hk, vk, fk;
            check("pix", {27'b0, obs}, {27'b0, exp_vec(k)});
            hk = k % HT;
            vk = (k / HT) % VT;
            fk = k / FT;
            if (hk == 0 && (vk < VSTART || vk >= VSTART + WH))
                check("addr_hold", {21'b0, addr_a}, (fk == 0 && vk < VSTART) ? 0 : LAST);
            if (rand_inputs && $urandom_range(0, 59) == 0) enable = ~enable;
            if (rand_inputs && $urandom_range(0, 59) == 0) invert = ~invert;
            en_hist[k]  = enable;
            inv_hist[k] = invert;
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic enter_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_pix", {27'b0, obs}, {27'b0, RST_VEC});
        check("rst_addr", {21'b0, addr_a}, 0);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; enable = 1'b1; invert = 1'b0;
        k = 0; n_checks = 0; n_pass = 0;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pix", {27'b0, obs}, {27'b0, RST_VEC});
        check("rst_addr", {21'b0, addr_a}, 0);

        // First byte 0xFC, everything else dark.
        mem[0] = 8'hFC;
        run_phase(2600, 1'b0);

        // Only the last bitmap byte lit, in its final bit.
        enter_reset();
        mem[0] = 8'h00;
        mem[LAST] = 8'h01;
        run_phase(2600, 1'b0);

        // All-zero bitmap inverted fills the window.
        enter_reset();
        mem[LAST] = 8'h00;
        invert = 1'b1;
        run_phase(2600, 1'b0);

        // Inverted but disabled: window dark, syncs unaffected.
        enter_reset();
        enable = 1'b0;
        run_phase(2600, 1'b0);

        // Random bitmap with random enable/invert changes, then a mid-frame reset.
        enter_reset();
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        enable = 1'b1;
        invert = 1'b0;
        run_phase(830, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", {27'b0, obs}, {27'b0, RST_VEC});
        check("rst_async_addr", {21'b0, addr_a}, 0);
        repeat (5) begin
            @(posedge clk); #1;
            check("rst_hold", {27'b0, obs}, {27'b0, RST_VEC});
        end
        run_phase(5000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
